cache_ctrl_sa: RTL and testbench

CACHE_CTRL_SA -- requirements
Module: cache_ctrl_sa

---
 rtl/cache_ctrl_sa_pkg.sv | 50 +++++
 rtl/cache_ctrl_sa_plru.sv | 37 +++
 rtl/cache_ctrl_sa.sv | 181 ++++++++++++++++++
 tb/tb_cache_ctrl_sa.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_sa_pkg.sv
// rtl/cache_ctrl_sa_pkg.sv - shared FSM states, address-field widths and PLRU helpers
package cache_ctrl_sa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_WRITE
    } state_t;

    function automatic int word_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_lsb(input int line_words, input int sets);
        return 2 + $clog2(line_words) + $clog2(sets);
    endfunction

    function automatic int way_bits(input int ways);
        return (ways > 2) ? 2 : 1;
    endfunction

    // Bits point away from the most recently touched side; 4-way uses st[0] as root,
    // st[1] for ways 0/1 and st[2] for ways 2/3.
    function automatic logic [1:0] plru_victim(input int ways, input logic [2:0] st);
        if (ways == 2)
            return {1'b0, st[0]};
        return st[0] ? {1'b1, st[2]} : {1'b0, st[1]};
    endfunction

    function automatic logic [2:0] plru_touch(input int ways, input logic [2:0] st,
                                              input logic [1:0] way);
        logic [2:0] nxt;
        nxt = st;
        if (ways == 2) begin
            nxt[0] = ~way[0];
        end else begin
            nxt[0] = ~way[1];
            if (way[1])
                nxt[2] = ~way[0];
            else
                nxt[1] = ~way[0];
        end
        return nxt;
    endfunction

endpackage

// File: rtl/cache_ctrl_sa_plru.sv
// rtl/cache_ctrl_sa_plru.sv - per-set replacement state with invalid-first victim choice
module cache_plru
    import cache_ctrl_sa_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int SETS = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [index_bits(SETS)-1:0] set_idx,
    input  logic [WAYS-1:0]            valid,
    input  logic                       touch_en,
    input  logic [way_bits(WAYS)-1:0]  touch_way,
    output logic [way_bits(WAYS)-1:0]  victim
);

    localparam int WW = way_bits(WAYS);

    logic [2:0] plru_q [SETS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++)
                plru_q[s] <= '0;
        end else if (touch_en) begin
            plru_q[set_idx] <= plru_touch(WAYS, plru_q[set_idx], 2'(touch_way));
        end
    end

    always_comb begin
        victim = WW'(plru_victim(WAYS, plru_q[set_idx]));
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid[w])
                victim = WW'(w);
    end

endmodule

// File: rtl/cache_ctrl_sa.sv
// rtl/cache_ctrl_sa.sv - set-associative write-through read cache; CACHE_STATS_EN adds hit/miss counters
module cache_ctrl_sa
    import cache_ctrl_sa_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 2,
    parameter int TAG_W      = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_en,
    input  logic                    wr_en,
    input  logic [31:0]             addr,
    input  logic [31:0]             wr_data,
    output logic [31:0]             rd_data,
    output logic                    rdy,
    output logic                    sram_rd_en,
    output logic                    sram_wr_en,
    output logic [31:0]             sram_addr,
    output logic [31:0]             sram_wr_data,
    input  logic                    sram_rdy,
    input  logic [32*LINE_WORDS-1:0] sram_rd_data
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]             hit_cnt,
    output logic [31:0]             miss_cnt
`endif
);

    localparam int WB = word_bits(LINE_WORDS);
    localparam int IB = index_bits(SETS);
    localparam int TL = tag_lsb(LINE_WORDS, SETS);
    localparam int WW = way_bits(WAYS);

    logic [TAG_W-1:0] tag_q   [WAYS][SETS];
    logic [31:0]      data_q  [WAYS][SETS][LINE_WORDS];
    logic [WAYS-1:0]  valid_q [SETS];

    state_t           state_q, state_d;
    logic             done_q;
    logic [WB-1:0]    word_sel;
    logic [IB-1:0]    set_idx;
    logic [TAG_W-1:0] req_tag;
    logic             hit;
    logic [WW-1:0]    hit_way, victim, touch_way;
    logic [31:0]      hit_word, fill_word;
    logic             touch_en, fill_we, wr_we;

    assign word_sel  = addr[2 +: WB];
    assign set_idx   = addr[2 + WB +: IB];
    assign req_tag   = addr[TL +: TAG_W];
    assign fill_word = sram_rd_data[32*word_sel +: 32];

    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[set_idx][w] && tag_q[w][set_idx] == req_tag) begin
                hit      = 1'b1;
                hit_way  = WW'(w);
                hit_word = data_q[w][set_idx][word_sel];
            end
        end
    end

    cache_plru #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_plru (
        .clk       (clk),
        .rst       (rst),
        .set_idx   (set_idx),
        .valid     (valid_q[set_idx]),
        .touch_en  (touch_en),
        .touch_way (touch_way),
        .victim    (victim)
    );

    // done_q blocks IDLE for one cycle after rdy so a still-held request cannot re-fire.
    always_comb begin
        state_d      = state_q;
        rdy          = 1'b0;
        rd_data      = '0;
        sram_rd_en   = 1'b0;
        sram_wr_en   = 1'b0;
        sram_addr    = '0;
        sram_wr_data = '0;
        touch_en     = 1'b0;
        touch_way    = hit_way;
        fill_we      = 1'b0;
        wr_we        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!done_q) begin
                    if (wr_en) begin
                        state_d = ST_WRITE;
                    end else if (rd_en) begin
                        if (hit) begin
                            rdy      = 1'b1;
                            rd_data  = hit_word;
                            touch_en = 1'b1;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end
                end
            end
            ST_FILL: begin
                sram_rd_en = 1'b1;
                sram_addr  = {addr[31:2+WB], {(2+WB){1'b0}}};
                if (sram_rdy) begin
                    rdy       = 1'b1;
                    rd_data   = fill_word;
                    fill_we   = 1'b1;
                    touch_en  = 1'b1;
                    touch_way = victim;
                    state_d   = ST_IDLE;
                end
            end
            ST_WRITE: begin
                sram_wr_en   = 1'b1;
                sram_addr    = addr;
                sram_wr_data = wr_data;
                if (sram_rdy) begin
                    rdy      = 1'b1;
                    wr_we    = hit;
                    touch_en = hit;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            for (int s = 0; s < SETS; s++)
                valid_q[s] <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= rdy;
            if (fill_we)
                valid_q[set_idx][victim] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && fill_we) begin
            tag_q[victim][set_idx] <= req_tag;
            for (int k = 0; k < LINE_WORDS; k++)
                data_q[victim][set_idx][k] <= sram_rd_data[32*k +: 32];
        end
        if (rst && wr_we)
            data_q[hit_way][set_idx][word_sel] <= wr_data;
    end

`ifdef CACHE_STATS_EN
    logic rd_accept, rd_hit_evt, rd_miss_evt;

    assign rd_accept   = (state_q == ST_IDLE) && !done_q && !wr_en && rd_en;
    assign rd_hit_evt  = rd_accept && hit;
    assign rd_miss_evt = rd_accept && !hit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (rd_hit_evt && hit_cnt != 32'hFFFF_FFFF)
                hit_cnt <= hit_cnt + 32'd1;
            if (rd_miss_evt && miss_cnt != 32'hFFFF_FFFF)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl_sa.sv
// tb/tb_cache_ctrl_sa.sv - scoreboard bench for 2-way and 4-way cache_ctrl_sa instances
module tb_cache_ctrl_sa;

    logic        clk;
    logic        rst;
    logic        rd_en        [2];
    logic        wr_en        [2];
    logic [31:0] addr         [2];
    logic [31:0] wr_data      [2];
    logic [31:0] rd_data      [2];
    logic        rdy          [2];
    logic        sram_rd_en   [2];
    logic        sram_wr_en   [2];
    logic [31:0] sram_addr    [2];
    logic [31:0] sram_wr_data [2];
    logic        sram_rdy     [2];
    logic [63:0] sram_rd_data [2];
`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt      [2];
    logic [31:0] miss_cnt     [2];
`endif

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mem [int];
    int          total = 0;
    int          bad   = 0;

    cache_ctrl_sa #(.WAYS(2), .SETS(64), .LINE_WORDS(2), .TAG_W(10)) u_dut2 (
        .clk(clk), .rst(rst), .rd_en(rd_en[0]), .wr_en(wr_en[0]), .addr(addr[0]),
        .wr_data(wr_data[0]), .rd_data(rd_data[0]), .rdy(rdy[0]),
        .sram_rd_en(sram_rd_en[0]), .sram_wr_en(sram_wr_en[0]), .sram_addr(sram_addr[0]),
        .sram_wr_data(sram_wr_data[0]), .sram_rdy(sram_rdy[0]), .sram_rd_data(sram_rd_data[0])
`ifdef CACHE_STATS_EN
        , .hit_cnt(hit_cnt[0]), .miss_cnt(miss_cnt[0])
`endif
    );

    cache_ctrl_sa #(.WAYS(4), .SETS(64), .LINE_WORDS(2), .TAG_W(10)) u_dut4 (
        .clk(clk), .rst(rst), .rd_en(rd_en[1]), .wr_en(wr_en[1]), .addr(addr[1]),
        .wr_data(wr_data[1]), .rd_data(rd_data[1]), .rdy(rdy[1]),
        .sram_rd_en(sram_rd_en[1]), .sram_wr_en(sram_wr_en[1]), .sram_addr(sram_addr[1]),
        .sram_wr_data(sram_wr_data[1]), .sram_rdy(sram_rdy[1]), .sram_rd_data(sram_rd_data[1])
`ifdef CACHE_STATS_EN
        , .hit_cnt(hit_cnt[1]), .miss_cnt(miss_cnt[1])
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        int k;
        k = int'(a >> 2);
        if (mem.exists(k))
            return mem[k];
        return {a[15:0], ~a[15:0]} ^ 32'h5EED_0000;
    endfunction

    function automatic logic [31:0] set_addr(input int tag, input int set);
        return (32'(tag) << 9) | (32'(set) << 3);
    endfunction

    // One request; the SRAM model answers after lat enabled cycles.
    task automatic req(input int d, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] wd, input int lat, input bit exp_hit);
        exp_t        e;
        exp_t        got_e;
        int          cnt;
        bit          got;
        bit          proto_bad;
        logic [31:0] la;
        la    = a & ~32'h7;
        e.data = w ? 32'h0 : mem_rd(a);
        e.cyc  = (r && !w && exp_hit) ? 0 : lat;
        sb.push_back(e);
        if (w)
            mem[int'(a >> 2)] = wd;
        @(posedge clk); #1;
        rd_en[d] = r; wr_en[d] = w; addr[d] = a; wr_data[d] = wd;
        cnt = 0; got = 0; proto_bad = 0;
        for (int cyc = 0; cyc < lat + 8 && !got; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
            end
            if (sram_rd_en[d] || sram_wr_en[d])
                cnt++;
            sram_rdy[d]     = (cnt == lat);
            sram_rd_data[d] = {mem_rd(la + 32'd4), mem_rd(la)};
            @(negedge clk);
            if (sram_rd_en[d] && sram_wr_en[d]) proto_bad = 1;
            if (w && sram_rd_en[d]) proto_bad = 1;
            if (sram_wr_en[d] && (sram_wr_data[d] !== wd || sram_addr[d] !== a)) proto_bad = 1;
            if (sram_rd_en[d] && sram_addr[d] !== la) proto_bad = 1;
            if (!rdy[d] && rd_data[d] !== 32'h0) proto_bad = 1;
            if (rdy[d] === 1'b1) begin
                got   = 1;
                got_e = sb.pop_front();
                total++;
                if (rd_data[d] !== got_e.data) begin
                    bad++;
                    $display("FAIL rd_data dut%0d addr=%h: got %h expected %h", d, a, rd_data[d], got_e.data);
                end
                total++;
                if (cyc !== got_e.cyc) begin
                    bad++;
                    $display("FAIL latency dut%0d addr=%h: got %0d expected %0d", d, a, cyc, got_e.cyc);
                end
            end
        end
        total++;
        if (!got) begin
            bad++;
            void'(sb.pop_front());
            $display("FAIL timeout dut%0d addr=%h: no rdy, expected rdy at cycle %0d", d, a, e.cyc);
        end
        total++;
        if (proto_bad !== 1'b0) begin
            bad++;
            $display("FAIL protocol dut%0d addr=%h: got violation=%0b expected 0", d, a, proto_bad);
        end
        @(posedge clk); #1;
        rd_en[d] = 0; wr_en[d] = 0; sram_rdy[d] = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({rdy[d], sram_rd_en[d], sram_wr_en[d]} !== 3'b000 || rd_data[d] !== 32'h0) begin
                bad++;
                $display("FAIL reset_outputs dut%0d: got rdy=%b srd=%b swr=%b rd_data=%h expected 0", d, rdy[d], sram_rd_en[d], sram_wr_en[d], rd_data[d]);
            end
`ifdef CACHE_STATS_EN
            total++;
            if (hit_cnt[d] !== 32'h0 || miss_cnt[d] !== 32'h0) begin
                bad++;
                $display("FAIL reset_stats dut%0d: got hit=%0d miss=%0d expected 0 0", d, hit_cnt[d], miss_cnt[d]);
            end
`endif
        end
        @(posedge clk); #1;
        rst = 1;
    endtask

    task automatic test_fill_hit();
        mem[0] = 32'hAAAA_AAAA;
        mem[1] = 32'hBBBB_BBBB;
        req(0, 1, 0, 32'h0000_0004, 32'h0, 3, 0);
        req(0, 1, 0, 32'h0000_0004, 32'h0, 3, 1);
        req(0, 1, 0, 32'h0000_0000, 32'h0, 3, 1);
`ifdef CACHE_STATS_EN
        @(negedge clk);
        total++;
        if (hit_cnt[0] !== 32'd2 || miss_cnt[0] !== 32'd1) begin
            bad++;
            $display("FAIL stats: got hit=%0d miss=%0d expected 2 1", hit_cnt[0], miss_cnt[0]);
        end
`endif
    endtask

    task automatic test_lru2();
        req(0, 1, 0, set_addr(1, 5), 32'h0, 2, 0);
        req(0, 1, 0, set_addr(2, 5), 32'h0, 2, 0);
        req(0, 1, 0, set_addr(1, 5) + 32'd4, 32'h0, 2, 1);
        req(0, 1, 0, set_addr(3, 5), 32'h0, 1, 0);
        req(0, 1, 0, set_addr(1, 5), 32'h0, 2, 1);
        req(0, 1, 0, set_addr(2, 5), 32'h0, 2, 0);
    endtask

    task automatic test_plru4();
        for (int t = 1; t <= 4; t++)
            req(1, 1, 0, set_addr(t, 7), 32'h0, 2, 0);
        for (int t = 1; t <= 3; t++)
            req(1, 1, 0, set_addr(t, 7), 32'h0, 2, 1);
        req(1, 1, 0, set_addr(5, 7), 32'h0, 2, 0);
        req(1, 1, 0, set_addr(2, 7), 32'h0, 2, 1);
        req(1, 1, 0, set_addr(3, 7), 32'h0, 2, 1);
        req(1, 1, 0, set_addr(5, 7) + 32'd4, 32'h0, 2, 1);
    endtask

    task automatic test_write();
        req(0, 0, 1, 32'h0000_0004, 32'h1234_5678, 3, 0);
        req(0, 1, 0, 32'h0000_0004, 32'h0, 2, 1);
        req(0, 0, 1, set_addr(9, 9), 32'h0BAD_F00D, 2, 0);
        req(0, 1, 0, set_addr(9, 9), 32'h0, 2, 0);
        req(0, 1, 0, set_addr(9, 9), 32'h0, 2, 1);
    endtask

    task automatic test_rd_wr_both();
        req(0, 1, 1, 32'h0000_0004, 32'hCAFE_0001, 2, 0);
        req(0, 1, 0, 32'h0000_0004, 32'h0, 2, 1);
    endtask

    task automatic test_reset_mid_fill();
        bit seen;
        @(posedge clk); #1;
        rd_en[0] = 1; addr[0] = 32'h0000_2000;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (sram_rd_en[0] !== 1'b1) begin
            bad++;
            $display("FAIL fill_entry: got sram_rd_en=%b expected 1", sram_rd_en[0]);
        end
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        rst = 1; rd_en[0] = 0;
        sram_rdy[0] = 1; sram_rd_data[0] = 64'hDEAD_BEEF_DEAD_BEEF;
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (rdy[0] !== 1'b0 || sram_rd_en[0] !== 1'b0) seen = 1;
            @(posedge clk); #1;
            sram_rdy[0] = 0;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL abandoned_fill: got rdy/sram_rd_en activity=%b expected 0", seen);
        end
`ifdef CACHE_STATS_EN
        total++;
        if (hit_cnt[0] !== 32'h0 || miss_cnt[0] !== 32'h0) begin
            bad++;
            $display("FAIL stats_after_reset: got hit=%0d miss=%0d expected 0 0", hit_cnt[0], miss_cnt[0]);
        end
`endif
        req(0, 1, 0, 32'h0000_2000, 32'h0, 2, 0);
        req(0, 1, 0, 32'h0000_0004, 32'h0, 2, 0);
    endtask

    initial begin
        clk = 0;
        rst = 0;
        for (int d = 0; d < 2; d++) begin
            rd_en[d] = 0; wr_en[d] = 0; addr[d] = '0; wr_data[d] = '0;
            sram_rdy[d] = 0; sram_rd_data[d] = '0;
        end
        test_reset();
        test_fill_hit();
        test_lru2();
        test_plru4();
        test_write();
        test_rd_wr_both();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
